// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register with stall, flush, valid tracking and a saturating bubble counter.
// The optional load-use hazard detector is enabled by defining IDEX_HAZARD_DETECT_EN.
module idex_stage_reg #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int WB_W      = 2,
    parameter int M_W       = 3,
    parameter int EX_W      = 4,
    parameter int MEMRD_BIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [REG_W-1:0]  Rs,
    input  logic [REG_W-1:0]  Rt,
    input  logic [REG_W-1:0]  Rd,
    input  logic [WB_W-1:0]   WB,
    input  logic [M_W-1:0]    M,
    input  logic [EX_W-1:0]   EX,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    input  logic [DATA_W-1:0] busC,
    output logic              out_valid,
    output logic [REG_W-1:0]  RsReg,
    output logic [REG_W-1:0]  RtReg,
    output logic [REG_W-1:0]  RdReg,
    output logic [WB_W-1:0]   WBReg,
    output logic [M_W-1:0]    MReg,
    output logic [EX_W-1:0]   EXReg,
    output logic [DATA_W-1:0] busAReg,
    output logic [DATA_W-1:0] busBReg,
    output logic [DATA_W-1:0] busCReg,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (MEMRD_BIT >= M_W) begin : g_memrd_range
        $error("MEMRD_BIT must index a bit of the M control group");
    end

    logic              valid_r;
    logic [REG_W-1:0]  rs_r;
    logic [REG_W-1:0]  rt_r;
    logic [REG_W-1:0]  rd_r;
    logic [WB_W-1:0]   wb_r;
    logic [M_W-1:0]    m_r;
    logic [EX_W-1:0]   ex_r;
    logic [DATA_W-1:0] bus_a_r;
    logic [DATA_W-1:0] bus_b_r;
    logic [DATA_W-1:0] bus_c_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              hazard_s;
    logic              bubble_s;
    logic              hold_data_s;

`ifdef IDEX_HAZARD_DETECT_EN
    // Load in EX whose destination feeds a source of the instruction now in decode.
    always_comb begin
        hazard_s = 1'b0;
        if (valid_r && m_r[MEMRD_BIT] && in_valid && (rt_r != {REG_W{1'b0}}) &&
            ((rt_r == Rs) || (rt_r == Rt))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end
`else
    assign hazard_s = 1'b0;
`endif

    // A bubble is inserted by flush regardless of stall; a hazard bubble yields to stall.
    always_comb begin
        bubble_s    = 1'b0;
        hold_data_s = 1'b0;
        if (flush) begin
            bubble_s    = 1'b1;
            hold_data_s = 1'b1;
        end else if (stall) begin
            bubble_s    = 1'b0;
            hold_data_s = 1'b1;
        end else if (hazard_s) begin
            bubble_s    = 1'b1;
            hold_data_s = 1'b1;
        end else begin
            bubble_s    = 1'b0;
            hold_data_s = 1'b0;
        end
    end

    // Valid bit and control groups: cleared on a bubble, held on stall, loaded otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            wb_r    <= {WB_W{1'b0}};
            m_r     <= {M_W{1'b0}};
            ex_r    <= {EX_W{1'b0}};
        end else if (bubble_s) begin
            valid_r <= 1'b0;
            wb_r    <= {WB_W{1'b0}};
            m_r     <= {M_W{1'b0}};
            ex_r    <= {EX_W{1'b0}};
        end else if (stall) begin
            valid_r <= valid_r;
            wb_r    <= wb_r;
            m_r     <= m_r;
            ex_r    <= ex_r;
        end else begin
            valid_r <= in_valid;
            wb_r    <= WB;
            m_r     <= M;
            ex_r    <= EX;
        end
    end

    // Specifiers and operand buses keep their last values across bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_r    <= {REG_W{1'b0}};
            rt_r    <= {REG_W{1'b0}};
            rd_r    <= {REG_W{1'b0}};
            bus_a_r <= {DATA_W{1'b0}};
            bus_b_r <= {DATA_W{1'b0}};
            bus_c_r <= {DATA_W{1'b0}};
        end else if (hold_data_s) begin
            rs_r    <= rs_r;
            rt_r    <= rt_r;
            rd_r    <= rd_r;
            bus_a_r <= bus_a_r;
            bus_b_r <= bus_b_r;
            bus_c_r <= bus_c_r;
        end else begin
            rs_r    <= Rs;
            rt_r    <= Rt;
            rd_r    <= Rd;
            bus_a_r <= busA;
            bus_b_r <= busB;
            bus_c_r <= busC;
        end
    end

    // Saturating bubble counter; one increment per bubble edge even if flush and hazard coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (bubble_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_valid    = valid_r;
    assign RsReg        = rs_r;
    assign RtReg        = rt_r;
    assign RdReg        = rd_r;
    assign WBReg        = wb_r;
    assign MReg         = m_r;
    assign EXReg        = ex_r;
    assign busAReg      = bus_a_r;
    assign busBReg      = bus_b_r;
    assign busCReg      = bus_c_r;
    assign hazard_stall = hazard_s;
    assign bubble_cnt   = cnt_r;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: directed vectors push hand-computed expectations,
// a monitor pops and compares them around each clock edge.
module tb_idex_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [4:0]  Rs, Rt, Rd;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic [3:0]  EX;
    logic [31:0] busA, busB, busC;
    logic        out_valid;
    logic [4:0]  RsReg, RtReg, RdReg;
    logic [1:0]  WBReg;
    logic [2:0]  MReg;
    logic [3:0]  EXReg;
    logic [31:0] busAReg, busBReg, busCReg;
    logic        hazard_stall;
    logic [2:0]  bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        haz;
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] a, b, c;
        logic [2:0]  cnt;
    } exp_t;

    exp_t q[$];

    idex_stage_reg #(.CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .WB(WB), .M(M), .EX(EX),
        .busA(busA), .busB(busB), .busC(busC),
        .out_valid(out_valid), .RsReg(RsReg), .RtReg(RtReg), .RdReg(RdReg),
        .WBReg(WBReg), .MReg(MReg), .EXReg(EXReg),
        .busAReg(busAReg), .busBReg(busBReg), .busCReg(busCReg),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic iv,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        stall = st; flush = fl; in_valid = iv;
        Rs = rs; Rt = rt; Rd = rd; WB = wb; M = m; EX = ex;
        busA = a; busB = b; busC = c;
    endtask

    task automatic expect_out(input logic haz, input logic v,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [2:0] cnt);
        exp_t e;
        e.haz = haz; e.v = v; e.rs = rs; e.rt = rt; e.rd = rd;
        e.wb = wb; e.m = m; e.ex = ex; e.a = a; e.b = b; e.c = c; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".RsReg"}, {27'd0, RsReg}, 32'd0);
        check({tag, ".RtReg"}, {27'd0, RtReg}, 32'd0);
        check({tag, ".RdReg"}, {27'd0, RdReg}, 32'd0);
        check({tag, ".ctrl"}, {23'd0, WBReg, MReg, EXReg}, 32'd0);
        check({tag, ".busAReg"}, busAReg, 32'd0);
        check({tag, ".busBReg"}, busBReg, 32'd0);
        check({tag, ".busCReg"}, busCReg, 32'd0);
        check({tag, ".bubble_cnt"}, {29'd0, bubble_cnt}, 32'd0);
        check({tag, ".hazard_stall"}, {31'd0, hazard_stall}, 32'd0);
    endtask

    // Monitor: hazard_stall is checked mid-low-phase, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.haz});
                @(posedge clk);
                #1;
                check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
                check("RsReg", {27'd0, RsReg}, {27'd0, e.rs});
                check("RtReg", {27'd0, RtReg}, {27'd0, e.rt});
                check("RdReg", {27'd0, RdReg}, {27'd0, e.rd});
                check("WBReg", {30'd0, WBReg}, {30'd0, e.wb});
                check("MReg", {29'd0, MReg}, {29'd0, e.m});
                check("EXReg", {28'd0, EXReg}, {28'd0, e.ex});
                check("busAReg", busAReg, e.a);
                check("busBReg", busBReg, e.b);
                check("busCReg", busCReg, e.c);
                check("bubble_cnt", {29'd0, bubble_cnt}, {29'd0, e.cnt});
            end
        end
    end

    task automatic drain();
        int waited;
        waited = 0;
        while (q.size() > 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries pending, expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2:0] c0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; WB = 2'd0; M = 3'd0; EX = 4'd0;
        busA = 32'd0; busB = 32'd0; busC = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("por");
        rst_n = 1'b1;

        // Plain load after reset release
        drive(1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 2'b11, 3'd0, 4'h0, 32'hDEADBEEF, 32'd1, 32'd2);
        expect_out(1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 2'b11, 3'd0, 4'h0, 32'hDEADBEEF, 32'd1, 32'd2, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd6, 5'd7, 2'b01, 3'd0, 4'hA, 32'h11, 32'h22, 32'h33);
        expect_out(1'b0, 1'b1, 5'd4, 5'd6, 5'd7, 2'b01, 3'd0, 4'hA, 32'h11, 32'h22, 32'h33, 3'd0);

        // Stall for three cycles while inputs change
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'd9, 5'd8, 5'd7, 2'b10, 3'b100, 4'h5,
                  32'hAAAA + i, 32'hBBBB, 32'hCCCC);
            expect_out(1'b0, 1'b1, 5'd4, 5'd6, 5'd7, 2'b01, 3'd0, 4'hA, 32'h11, 32'h22, 32'h33, 3'd0);
        end
        drive(1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd7, 2'b10, 3'b100, 4'h5, 32'hAAAA, 32'hBBBB, 32'hCCCC);
        expect_out(1'b0, 1'b1, 5'd9, 5'd8, 5'd7, 2'b10, 3'b100, 4'h5, 32'hAAAA, 32'hBBBB, 32'hCCCC, 3'd0);

        // Flush wins over stall: control cleared, specifiers and buses held
        drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 2'b11, 3'b111, 4'hF, 32'h1, 32'h1, 32'h1);
        expect_out(1'b0, 1'b0, 5'd9, 5'd8, 5'd7, 2'b00, 3'd0, 4'h0, 32'hAAAA, 32'hBBBB, 32'hCCCC, 3'd1);

        // Load-use pair: a load writing r5 followed by a consumer of r5
        drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd5, 5'd2, 2'b01, 3'b010, 4'h2, 32'd100, 32'd200, 32'd300);
        expect_out(1'b0, 1'b1, 5'd1, 5'd5, 5'd2, 2'b01, 3'b010, 4'h2, 32'd100, 32'd200, 32'd300, 3'd1);
        drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd4, 2'b10, 3'd0, 4'h3, 32'd5, 32'd6, 32'd7);
`ifdef IDEX_HAZARD_DETECT_EN
        expect_out(1'b1, 1'b0, 5'd1, 5'd5, 5'd2, 2'b00, 3'd0, 4'h0, 32'd100, 32'd200, 32'd300, 3'd2);
        c0 = 3'd2;
`else
        expect_out(1'b0, 1'b1, 5'd5, 5'd3, 5'd4, 2'b10, 3'd0, 4'h3, 32'd5, 32'd6, 32'd7, 3'd1);
        c0 = 3'd1;
`endif
        drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd4, 2'b10, 3'd0, 4'h3, 32'd5, 32'd6, 32'd7);
        expect_out(1'b0, 1'b1, 5'd5, 5'd3, 5'd4, 2'b10, 3'd0, 4'h3, 32'd5, 32'd6, 32'd7, c0);

        // Load into r0 never raises a hazard
        drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 2'b01, 3'b010, 4'h1, 32'd1, 32'd2, 32'd3);
        expect_out(1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 2'b01, 3'b010, 4'h1, 32'd1, 32'd2, 32'd3, c0);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 2'b11, 3'd0, 4'h4, 32'h9, 32'hA, 32'hB);
        expect_out(1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 2'b11, 3'd0, 4'h4, 32'h9, 32'hA, 32'hB, c0);

        // Ten consecutive flushes saturate the 3-bit counter at 7
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 5'd2, 2'b11, 3'b111, 4'hF, 32'h5, 32'h5, 32'h5);
            expect_out(1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 2'b00, 3'd0, 4'h0, 32'h9, 32'hA, 32'hB,
                       ((int'(c0) + i) > 7) ? 3'd7 : 3'(int'(c0) + i));
        end
        drive(1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 2'b11, 3'b111, 4'hF, 32'h5, 32'h5, 32'h5);
        expect_out(1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 2'b00, 3'd0, 4'h0, 32'h9, 32'hA, 32'hB, 3'd7);
        drive(1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd2, 2'b11, 3'b111, 4'hF, 32'h5, 32'h5, 32'h5);
        expect_out(1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 2'b00, 3'd0, 4'h0, 32'h9, 32'hA, 32'hB, 3'd7);
        drain();

        // Asynchronous reset between edges while stalled with nonzero state
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;

        // First edge after reset release performs a normal load
        drive(1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 2'b11, 3'd0, 4'h0, 32'hDEADBEEF, 32'd0, 32'd0);
        expect_out(1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 2'b11, 3'd0, 4'h0, 32'hDEADBEEF, 32'd0, 32'd0, 3'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
